// File: rtl/exec_pkg.sv
// Shared types for the execute-stage issue controller: ALU op codes,
// the buffered instruction format, sequencer states and a width helper.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SLT
    } ALU_OP_CODE;

    typedef struct packed {
        ALU_OP_CODE  op_code;
        logic [31:0] input_A;
        logic [31:0] input_B;
        logic        reg_out;
        logic [4:0]  reg_addr;
        logic        mem_out;
        logic [31:0] mem_addr;
        logic        pc_jump;
    } exec_instr_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ERROR
    } exec_state_t;

    // Bits needed to hold any value in 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/exec_instr_fifo.sv
// Small instruction FIFO with push/pop/flush; also exposes the head that
// will be visible after the current edge so the issuer can preload it.
module exec_instr_fifo
    import exec_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  exec_instr_t              push_data,
    input  logic                     pop,
    input  logic                     flush,
    output exec_instr_t              head,
    output exec_instr_t              head_next,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     full,
    output logic                     empty,
    output logic                     empty_next
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_w(DEPTH);

    exec_instr_t   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_inc;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign do_pop     = pop && !empty;
    assign do_push    = push && !flush && !full;
    assign rd_ptr_inc = rd_ptr + PW'(1);
    assign head       = empty ? '0 : mem[rd_ptr];
    assign empty_next = (count_next == '0);

    always_comb begin
        count_next = count;
        head_next  = '0;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(do_push) - CW'(do_pop);
            // After a pop the new head is the second entry, or the word
            // being written this cycle when only one entry was held.
            if (do_pop) begin
                if (count > CW'(1))
                    head_next = mem[rd_ptr_inc];
                else if (do_push)
                    head_next = push_data;
            end else if (!empty) begin
                head_next = head;
            end else if (do_push) begin
                head_next = push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (do_pop)
                    rd_ptr <= rd_ptr_inc;
                if (do_push)
                    wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/exec_sequencer.sv
// Issue controller between decode and the ALU: buffers instructions, issues
// one at a time, flushes younger entries on a completed jump, flags hangs.
module exec_sequencer
    import exec_pkg::*;
#(
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  exec_instr_t       dec_instr,
    output ALU_OP_CODE        alu_op_code,
    output logic [31:0]       alu_input_A,
    output logic [31:0]       alu_input_B,
    output logic              alu_reg_out,
    output logic [4:0]        alu_reg_addr,
    output logic              alu_mem_out,
    output logic [31:0]       alu_mem_addr,
    output logic              alu_pc_jump,
    output logic              alu_inputs_valid,
    input  logic              alu_done,
    output logic              busy,
    output logic [CNT_W-1:0]  issued_count,
    output logic [CNT_W-1:0]  flushed_count,
    output logic              timeout_err
);

    localparam int unsigned FCW = cnt_w(DEPTH);
    localparam int unsigned TW  = cnt_w(TIMEOUT_CYCLES);

    exec_state_t     state;
    exec_state_t     state_next;
    exec_instr_t     head;
    exec_instr_t     head_next;
    exec_instr_t     alu_q;
    logic [FCW-1:0]  fifo_count;
    logic            full;
    logic            empty;
    logic            empty_next;
    logic [TW-1:0]   wait_cnt;
    logic            head_loaded;
    logic            done_now;
    logic            flush_now;
    logic            push;

    assign done_now  = (state == WAIT) && alu_done;
    assign flush_now = done_now && head.pc_jump;
    assign dec_ready = !full && !flush_now && (state != ERROR);
    assign push      = dec_valid && dec_ready;

    exec_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push       (push),
        .push_data  (dec_instr),
        .pop        (done_now),
        .flush      (flush_now),
        .head       (head),
        .head_next  (head_next),
        .count      (fifo_count),
        .full       (full),
        .empty      (empty),
        .empty_next (empty_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (head_loaded) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (alu_done)
                    state_next = empty_next ? IDLE : ISSUE;
                else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1))
                    state_next = ERROR;
            end
            ERROR:   state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    // In IDLE the head is first captured into the ALU register, and the
    // issue waits one cycle for that capture to be visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_q         <= '0;
            head_loaded   <= 1'b0;
            wait_cnt      <= '0;
            issued_count  <= '0;
            flushed_count <= '0;
        end else begin
            head_loaded <= (state == IDLE) && !empty;
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + TW'(1);
            if (done_now)
                alu_q <= head_next;
            else if (state == IDLE)
                alu_q <= head;
            if (done_now)
                issued_count <= issued_count + CNT_W'(1);
            if (flush_now)
                flushed_count <= flushed_count + CNT_W'(fifo_count - FCW'(1));
        end
    end

    assign alu_inputs_valid = (state == ISSUE);
    assign timeout_err      = (state == ERROR);
    assign busy             = (state != IDLE) || !empty;

    assign alu_op_code  = alu_q.op_code;
    assign alu_input_A  = alu_q.input_A;
    assign alu_input_B  = alu_q.input_B;
    assign alu_reg_out  = alu_q.reg_out;
    assign alu_reg_addr = alu_q.reg_addr;
    assign alu_mem_out  = alu_q.mem_out;
    assign alu_mem_addr = alu_q.mem_addr;
    assign alu_pc_jump  = alu_q.pc_jump;

endmodule
